// File: rtl/entry_input_capture.sv
// entry_input_capture: synchronises and debounces the raw NEXT push-button
// and, on every accepted press, snapshots the Din/MS/level switches into a
// single entry that is offered to the control FSM over a valid/ack handshake.
module entry_input_capture #(
  parameter int DB_CYCLES = 250000,
  parameter int DW        = 4
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          key_n_raw,
  input  logic [DW-1:0] din_raw,
  input  logic [2:0]    ms_raw,
  input  logic          level_raw,
  output logic          entry_valid,
  input  logic          entry_ack,
  output logic [DW-1:0] din_out,
  output logic [2:0]    ms_out,
  output logic          level_out,
  output logic          overrun,
  output logic [7:0]    press_cnt
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_PRESS_WT = 2'd1;
  localparam logic [1:0]  ST_HELD     = 2'd2;
  localparam logic [1:0]  ST_REL_WT   = 2'd3;
  localparam logic [19:0] CNT_LAST    = 20'(DB_CYCLES - 1);

  logic          key_meta_q, key_s_q;
  logic [DW-1:0] din_meta_q, din_s_q;
  logic [2:0]    ms_meta_q, ms_s_q;
  logic          lvl_meta_q, lvl_s_q;

  logic [1:0]    state_q, state_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          capture;
  logic          pressed;

  logic          entry_valid_q, entry_valid_d;
  logic [DW-1:0] din_out_q, din_out_d;
  logic [2:0]    ms_out_q, ms_out_d;
  logic          level_out_q, level_out_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    press_cnt_q, press_cnt_d;

  assign pressed = ~key_s_q;

  // Two-flop synchronisers; the key idles high so reset loads it released.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      din_meta_q <= '0;
      din_s_q    <= '0;
      ms_meta_q  <= '0;
      ms_s_q     <= '0;
      lvl_meta_q <= 1'b0;
      lvl_s_q    <= 1'b0;
    end else begin
      key_meta_q <= key_n_raw;
      key_s_q    <= key_meta_q;
      din_meta_q <= din_raw;
      din_s_q    <= din_meta_q;
      ms_meta_q  <= ms_raw;
      ms_s_q     <= ms_meta_q;
      lvl_meta_q <= level_raw;
      lvl_s_q    <= lvl_meta_q;
    end
  end

  // Debounce FSM: a level must persist for DB_CYCLES counted clocks before it
  // is accepted; acceptance of a press is the capture event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_WT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WT: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_REL_WT;
          cnt_d   = '0;
        end
      end
      ST_REL_WT: begin
        if (pressed) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Entry handshake: a capture loads new data only if the slot is free or is
  // being acked on the same edge; otherwise the press is flagged as overrun.
  always_comb begin
    entry_valid_d = entry_valid_q;
    din_out_d     = din_out_q;
    ms_out_d      = ms_out_q;
    level_out_d   = level_out_q;
    overrun_d     = overrun_q;
    press_cnt_d   = press_cnt_q;
    if (capture) begin
      press_cnt_d = press_cnt_q + 8'd1;
      if (!entry_valid_q || entry_ack) begin
        entry_valid_d = 1'b1;
        din_out_d     = din_s_q;
        ms_out_d      = ms_s_q;
        level_out_d   = lvl_s_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (entry_valid_q && entry_ack) begin
      entry_valid_d = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      entry_valid_q <= 1'b0;
      din_out_q     <= '0;
      ms_out_q      <= '0;
      level_out_q   <= 1'b0;
      overrun_q     <= 1'b0;
      press_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      entry_valid_q <= entry_valid_d;
      din_out_q     <= din_out_d;
      ms_out_q      <= ms_out_d;
      level_out_q   <= level_out_d;
      overrun_q     <= overrun_d;
      press_cnt_q   <= press_cnt_d;
    end
  end

  assign entry_valid = entry_valid_q;
  assign din_out     = din_out_q;
  assign ms_out      = ms_out_q;
  assign level_out   = level_out_q;
  assign overrun     = overrun_q;
  assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_entry_input_capture.sv
// Testbench for entry_input_capture: directed scenarios plus randomized key
// bouncing, all compared every cycle against an event-level reference model.
module tb_entry_input_capture;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       key_n_raw;
  logic [3:0] din_raw;
  logic [2:0] ms_raw;
  logic       level_raw;
  logic       entry_ack;
  logic       entry_valid;
  logic [3:0] din_out;
  logic [2:0] ms_out;
  logic       level_out;
  logic       overrun;
  logic [7:0] press_cnt;

  int totalChecks = 0;
  int badChecks   = 0;
  bit checkEn     = 1'b0;

  entry_input_capture #(.DB_CYCLES(DB), .DW(4)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .key_n_raw  (key_n_raw),
    .din_raw    (din_raw),
    .ms_raw     (ms_raw),
    .level_raw  (level_raw),
    .entry_valid(entry_valid),
    .entry_ack  (entry_ack),
    .din_out    (din_out),
    .ms_out     (ms_out),
    .level_out  (level_out),
    .overrun    (overrun),
    .press_cnt  (press_cnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model: raw samples reach the debouncer two edges late; a level
  // opposite to the accepted one must be seen DB+1 edges in a row to flip it.
  typedef struct packed {
    logic       key;
    logic [3:0] din;
    logic [2:0] ms;
    logic       lvl;
  } sample_t;

  sample_t    hist[$];
  sample_t    smp;
  sample_t    idleSmp;
  bit         mPressed = 1'b0;
  int         mRun     = 0;
  bit         mCapture = 1'b0;
  bit         mValid   = 1'b0;
  logic [3:0] mDin     = '0;
  logic [2:0] mMs      = '0;
  logic       mLvl     = 1'b0;
  bit         mOverrun = 1'b0;
  logic [7:0] mCnt     = '0;

  // Model update at every edge, cleared immediately on reset.
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      idleSmp = '0;
      idleSmp.key = 1'b1;
      hist.delete();
      hist.push_back(idleSmp);
      hist.push_back(idleSmp);
      mPressed = 1'b0;
      mRun = 0;
      mValid = 1'b0;
      mDin = '0;
      mMs = '0;
      mLvl = 1'b0;
      mOverrun = 1'b0;
      mCnt = '0;
    end else begin
      smp = hist.pop_front();
      hist.push_back({key_n_raw, din_raw, ms_raw, level_raw});
      mCapture = 1'b0;
      if ((smp.key == 1'b0) != mPressed) begin
        mRun++;
        if (mRun == DB + 1) begin
          mPressed = !mPressed;
          mRun = 0;
          mCapture = mPressed;
        end
      end else begin
        mRun = 0;
      end
      if (mCapture) begin
        mCnt = mCnt + 8'd1;
        if (!mValid || entry_ack) begin
          mValid = 1'b1;
          mDin = smp.din;
          mMs = smp.ms;
          mLvl = smp.lvl;
        end else begin
          mOverrun = 1'b1;
        end
      end else if (mValid && entry_ack) begin
        mValid = 1'b0;
      end
    end
  end

  logic [31:0] dutVec, modelVec;
  assign dutVec   = {14'd0, entry_valid, din_out, ms_out, level_out, overrun, press_cnt};
  assign modelVec = {14'd0, mValid, mDin, mMs, mLvl, mOverrun, mCnt};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic k, input logic [3:0] d, input logic [2:0] m,
                               input logic l, input logic a, input int n);
    key_n_raw = k;
    din_raw   = d;
    ms_raw    = m;
    level_raw = l;
    entry_ack = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseReset(input string tag);
    #2 clear_n = 1'b0;
    #1 checkOutput(tag, dutVec, 32'd0);
    key_n_raw = 1'b1;
    entry_ack = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) checkOutput("cycle", dutVec, modelVec);
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int segLen;
    logic [3:0] d;
    logic [2:0] m;
    logic l;

    clear_n = 1'b0;
    key_n_raw = 1'b1;
    din_raw = '0;
    ms_raw = '0;
    level_raw = 1'b0;
    entry_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset_state", dutVec, 32'd0);
    clear_n = 1'b1;
    @(negedge clk);

    $display("[TB] short bounces");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'hA, 3'd5, 1'b1, 1'b0, 3);
      applyStimulus(1'b1, 4'hA, 3'd5, 1'b1, 1'b0, 3);
    end
    applyStimulus(1'b1, 4'hA, 3'd5, 1'b1, 1'b0, 10);
    checkOutput("bounce_valid", entry_valid, 32'd0);
    checkOutput("bounce_cnt", press_cnt, 32'd0);

    $display("[TB] clean press latency");
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 4'hA, 3'd5, 1'b1, 1'b0, 1);
      if (entry_valid && lat == 0) lat = k;
    end
    checkOutput("latency", lat, 32'd7);
    checkOutput("first_din", din_out, 32'hA);
    checkOutput("first_ms", ms_out, 32'd5);
    checkOutput("first_lvl", level_out, 32'd1);
    checkOutput("first_cnt", press_cnt, 32'd1);
    applyStimulus(1'b1, 4'hA, 3'd5, 1'b1, 1'b0, 10);

    $display("[TB] pending entry holds data");
    applyStimulus(1'b1, 4'h3, 3'd2, 1'b0, 1'b0, 50);
    checkOutput("hold_valid", entry_valid, 32'd1);
    checkOutput("hold_din", din_out, 32'hA);

    $display("[TB] overrun");
    applyStimulus(1'b0, 4'h3, 3'd2, 1'b0, 1'b0, 12);
    checkOutput("ovr_flag", overrun, 32'd1);
    checkOutput("ovr_din", din_out, 32'hA);
    checkOutput("ovr_cnt", press_cnt, 32'd2);
    applyStimulus(1'b1, 4'h3, 3'd2, 1'b0, 1'b0, 10);
    applyStimulus(1'b1, 4'h3, 3'd2, 1'b0, 1'b1, 1);
    checkOutput("ack_drop", entry_valid, 32'd0);
    applyStimulus(1'b1, 4'h3, 3'd2, 1'b0, 1'b1, 2);
    checkOutput("ack_idle_ignored", entry_valid, 32'd0);
    applyStimulus(1'b1, 4'h3, 3'd2, 1'b0, 1'b0, 2);

    $display("[TB] capture coinciding with ack");
    pulseReset("reset_before_coincide");
    applyStimulus(1'b0, 4'h6, 3'd1, 1'b0, 1'b0, 12);
    applyStimulus(1'b1, 4'h6, 3'd1, 1'b0, 1'b0, 10);
    applyStimulus(1'b0, 4'h9, 3'd7, 1'b1, 1'b0, 6);
    applyStimulus(1'b0, 4'h9, 3'd7, 1'b1, 1'b1, 1);
    checkOutput("coin_valid", entry_valid, 32'd1);
    checkOutput("coin_din", din_out, 32'h9);
    checkOutput("coin_ms", ms_out, 32'd7);
    checkOutput("coin_ovr", overrun, 32'd0);
    checkOutput("coin_cnt", press_cnt, 32'd2);
    applyStimulus(1'b0, 4'h9, 3'd7, 1'b1, 1'b0, 5);
    applyStimulus(1'b1, 4'h9, 3'd7, 1'b1, 1'b0, 10);
    applyStimulus(1'b1, 4'h9, 3'd7, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 4'h9, 3'd7, 1'b1, 1'b0, 2);

    $display("[TB] async reset mid debounce and mid handshake");
    applyStimulus(1'b0, 4'h5, 3'd3, 1'b1, 1'b0, 4);
    pulseReset("reset_mid_press");
    applyStimulus(1'b1, 4'h5, 3'd3, 1'b1, 1'b0, 20);
    checkOutput("no_capture_after_reset", entry_valid, 32'd0);
    applyStimulus(1'b0, 4'h5, 3'd3, 1'b1, 1'b0, 12);
    checkOutput("valid_before_reset", entry_valid, 32'd1);
    pulseReset("reset_while_valid");
    applyStimulus(1'b1, 4'h5, 3'd3, 1'b1, 1'b0, 10);
    checkOutput("valid_after_reset", entry_valid, 32'd0);

    $display("[TB] 256 acked presses");
    pulseReset("reset_before_wrap");
    for (int i = 0; i < 256; i++) begin
      d = 4'($urandom);
      m = 3'($urandom);
      l = 1'($urandom);
      applyStimulus(1'b0, d, m, l, 1'b0, $urandom_range(8, 12));
      checkOutput("press_valid", entry_valid, 32'd1);
      checkOutput("press_din", din_out, {28'd0, d});
      applyStimulus(1'b0, d, m, l, 1'b1, 1);
      applyStimulus(1'b1, d, m, l, 1'b0, $urandom_range(8, 12));
    end
    checkOutput("wrap_cnt", press_cnt, 32'd0);
    checkOutput("wrap_ovr", overrun, 32'd0);

    $display("[TB] random bouncing");
    for (int c = 0; c < 600; c += segLen) begin
      segLen = $urandom_range(1, 9);
      applyStimulus(1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), segLen);
    end
    applyStimulus(1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 10);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
